// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and helpers for the toggle-cell counter
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Widest counter the helper serves; callers zero-extend into it.
    localparam int CLAMP_W = 32;

    // Saturate a parallel-load value to the top of the count range.
    function automatic logic [CLAMP_W-1:0] clamp_load(input logic [CLAMP_W-1:0] d,
                                                      input logic [CLAMP_W-1:0] max);
        return (d > max) ? max : d;
    endfunction

endpackage

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - single T-type toggle storage bit with load override
module tff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    input  logic ld,
    input  logic ld_val,
    output logic q
);

    // Load wins over toggle; with neither asserted the bit holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (ld) begin
            q <= ld_val;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_updown_counter.sv
// rtl/tff_updown_counter.sv - modulo-N up/down counter built from toggle cells
module tff_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int MODULO = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] q_eff;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] t;
    logic             step_wrap;

    // Next count: out-of-range states are folded onto MAX so one step re-enters range.
    // The load value is gated by load so an undriven d cannot leak into the toggles.
    always_comb begin
        q_eff  = (q > MAX) ? MAX : q;
        ld_val = '0;
        if (load) begin
            ld_val = WIDTH'(clamp_load(CLAMP_W'(d), CLAMP_W'(MAX)));
        end
        next_q = q;
        if (load) begin
            next_q = ld_val;
        end else if (en) begin
            if (up == DIR_UP) begin
                next_q = (q_eff == MAX) ? '0 : q_eff + 1'b1;
            end else begin
                next_q = (q == '0) ? MAX : q_eff - 1'b1;
            end
        end
        t = q ^ next_q;
    end

    // Terminal count and the wrap decision for the coming edge.
    always_comb begin
        tc        = en & ~load & ((up == DIR_UP) ? (q == MAX) : (q == '0));
        step_wrap = en & ~load & ((up == DIR_UP) ? (q_eff == MAX) : (q == '0));
    end

    // One toggle cell per count bit; each bit changes only when its toggle is set.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .t      (t[i]),
            .ld     (load),
            .ld_val (ld_val[i]),
            .q      (q[i])
        );
    end

    // Registered wrap pulse, high for the cycle after a wrapping step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap <= 1'b0;
        end else begin
            wrap <= step_wrap;
        end
    end

endmodule

// File: tb/tb_tff_updown_counter.sv
// tb/tb_tff_updown_counter.sv - self-checking bench for tff_updown_counter
module tb_tff_updown_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] d;
    logic [3:0] q10;
    logic [3:0] q16;
    logic       tc10;
    logic       tc16;
    logic       wrap10;
    logic       wrap16;

    int checks = 0;
    int errors = 0;
    int mq10   = 0;
    int mq16   = 0;
    int mw10   = 0;
    int mw16   = 0;
    int wrap_count;

    always #5 clk = ~clk;

    tff_updown_counter #(.WIDTH(4), .MODULO(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .d(d),
        .q(q10), .tc(tc10), .wrap(wrap10)
    );

    tff_updown_counter #(.WIDTH(4), .MODULO(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .d(d),
        .q(q16), .tc(tc16), .wrap(wrap16)
    );

    function automatic int model_next(int q, int m, bit e, bit u, bit l, int dv);
        if (l) return (dv > m - 1) ? m - 1 : dv;
        if (e && u) return (q + 1) % m;
        if (e && !u) return (q + m - 1) % m;
        return q;
    endfunction

    function automatic int model_wrap(int q, int m, bit e, bit u, bit l);
        return (e && !l && ((u && q == m - 1) || (!u && q == 0))) ? 1 : 0;
    endfunction

    // Drive one cycle of inputs, check tc before the edge and q/wrap after it.
    task automatic step(input bit e, input bit u, input bit l, input int dv, input string name);
        int etc10;
        int etc16;
        en = e; up = u; load = l; d = 4'(dv);
        #1;
        etc10 = model_wrap(mq10, 10, e, u, l);
        etc16 = model_wrap(mq16, 16, e, u, l);
        checks++;
        if (tc10 !== 1'(etc10)) begin
            errors++;
            $display("FAIL %s tc10: got %0b expected %0d (q=%0d)", name, tc10, etc10, mq10);
        end
        checks++;
        if (tc16 !== 1'(etc16)) begin
            errors++;
            $display("FAIL %s tc16: got %0b expected %0d (q=%0d)", name, tc16, etc16, mq16);
        end
        @(posedge clk);
        mw10 = etc10;
        mw16 = etc16;
        mq10 = model_next(mq10, 10, e, u, l, dv);
        mq16 = model_next(mq16, 16, e, u, l, dv);
        #1;
        checks++;
        if (q10 !== 4'(mq10) || wrap10 !== 1'(mw10)) begin
            errors++;
            $display("FAIL %s mod10: got q=%0d wrap=%0b expected q=%0d wrap=%0d", name, q10, wrap10, mq10, mw10);
        end
        checks++;
        if (q16 !== 4'(mq16) || wrap16 !== 1'(mw16)) begin
            errors++;
            $display("FAIL %s mod16: got q=%0d wrap=%0b expected q=%0d wrap=%0d", name, q16, wrap16, mq16, mw16);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; d = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (q10 !== 4'd0 || wrap10 !== 1'b0 || q16 !== 4'd0 || wrap16 !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: got q10=%0d w10=%0b q16=%0d w16=%0b expected all 0", q10, wrap10, q16, wrap16);
        end
        rst_n = 1'b1;
        step(0, 1, 1, 8, "reset_load8");
        step(1, 1, 0, 0, "reset_to9");
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (q10 !== 4'd0 || wrap10 !== 1'b0 || q16 !== 4'd0 || wrap16 !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got q10=%0d w10=%0b q16=%0d w16=%0b expected all 0", q10, wrap10, q16, wrap16);
        end
        mq10 = 0; mq16 = 0; mw10 = 0; mw16 = 0;
        en = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, "reset_hold");
    endtask

    task automatic test_count_up();
        wrap_count = 0;
        step(0, 1, 1, 0, "up_load0");
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0, 0, "up_mod10");
            if (wrap10 === 1'b1) wrap_count++;
        end
        checks++;
        if (wrap_count != 1) begin
            errors++;
            $display("FAIL up_wrap_count: got %0d expected 1", wrap_count);
        end
    endtask

    task automatic test_count_down();
        step(0, 0, 1, 1, "down_load1");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, "down_mod10");
    endtask

    task automatic test_load_clamp();
        step(1, 1, 1, 13, "clamp_load13");
        step(1, 1, 0, 0, "clamp_then_up");
    endtask

    task automatic test_dir_toggle();
        wrap_count = 0;
        step(0, 1, 1, 5, "dir_load5");
        for (int i = 0; i < 4; i++) begin
            step(1, (i % 2) == 0, 0, 0, "dir_toggle");
            if (wrap10 === 1'b1 || wrap16 === 1'b1) wrap_count++;
        end
        checks++;
        if (wrap_count != 0) begin
            errors++;
            $display("FAIL dir_no_wrap: got %0d pulses expected 0", wrap_count);
        end
    endtask

    task automatic test_wrap16();
        logic [3:0] et;
        step(0, 1, 1, 15, "w16_load15");
        en = 1'b1; up = 1'b1; load = 1'b0; d = 4'd0;
        #1;
        et = 4'(mq16) ^ 4'(model_next(mq16, 16, 1, 1, 0, 0));
        checks++;
        if (dut16.t !== et) begin
            errors++;
            $display("FAIL w16_toggles: got %b expected %b", dut16.t, et);
        end
        step(1, 1, 0, 0, "w16_wrap");
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load_clamp();
        test_dir_toggle();
        test_wrap16();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
